mem_bus_arbiter: RTL and testbench

- Shares the single memory port between the fetch stage (instruction requests) and the memory stage (LD/SD data requests).
- Grants one outstanding transaction at a time and latches the winning request into registers.
- Drives the downstream port from those registers and steers the one-cycle response back to the winner.
- Data requests win by default; a streak counter prevents fetch starvation.

---
 rtl/mem_bus_arbiter_pkg.sv | 28 ++
 rtl/mem_bus_arbiter_if.sv | 50 +++++
 rtl/mem_bus_arbiter_streak_ctr.sv | 38 +++
 rtl/mem_bus_arbiter.sv | 118 +++++++++++
 tb/tb_mem_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the memory-port arbiter: request/response records and the arbiter state encoding.
package mem_bus_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W     = 64;
    localparam int unsigned MEM_DATA_W     = 64;
    localparam int unsigned MEM_STRB_W     = 8;
    localparam int unsigned ARB_MAX_STREAK = 4;

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  ok;
        logic [MEM_DATA_W-1:0] data;
    } mem_resp_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, data and downstream memory handshakes around the arbiter.
// Handshake: a requester holds *_valid with stable payload until its one-cycle *_ok pulse;
// the arbiter holds mreq_* stable until mresp_ok, which is a one-cycle completion pulse.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
) ();

    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              iresp_ok;
    logic [DATA_W-1:0] iresp_data;

    logic              dreq_valid;
    logic              dreq_write;
    logic [ADDR_W-1:0] dreq_addr;
    logic [7:0]        dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dresp_ok;
    logic [DATA_W-1:0] dresp_data;

    logic              mreq_valid;
    logic              mreq_write;
    logic [ADDR_W-1:0] mreq_addr;
    logic [7:0]        mreq_strobe;
    logic [DATA_W-1:0] mreq_wdata;
    logic              mresp_ok;
    logic [DATA_W-1:0] mresp_data;

    // Arbiter side.
    modport slave (
        input  ireq_valid, ireq_addr,
        output iresp_ok, iresp_data,
        input  dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
        output dresp_ok, dresp_data,
        output mreq_valid, mreq_write, mreq_addr, mreq_strobe, mreq_wdata,
        input  mresp_ok, mresp_data
    );

    // Requesters and memory side.
    modport master (
        output ireq_valid, ireq_addr,
        input  iresp_ok, iresp_data,
        output dreq_valid, dreq_write, dreq_addr, dreq_strobe, dreq_wdata,
        input  dresp_ok, dresp_data,
        input  mreq_valid, mreq_write, mreq_addr, mreq_strobe, mreq_wdata,
        output mresp_ok, mresp_data
    );

endinterface

// File: rtl/mem_bus_arbiter_streak_ctr.sv
// Saturating count of consecutive data grants taken while a fetch was waiting.
module arb_streak_ctr #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned CNT_W      = $clog2(MAX_STREAK + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] count_o,
    output logic             at_max_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign at_max_o = (cnt_q == CNT_W'(MAX_STREAK));
    assign count_o  = cnt_q;

    // Clear wins over increment; increment stops at the cap.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !at_max_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between fetch and data requesters, one transaction at a time.
// Data wins by default; after MAX_STREAK data grants with fetch waiting, fetch is forced through.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                               clk,
    input  logic                               resetn,
    mem_bus_arbiter_if.slave                   bus,
    output logic                               busy,
    output arb_state_t                         dbg_state,
    output logic [$clog2(MAX_STREAK + 1)-1:0]  dbg_streak
);

    localparam int unsigned CNT_W = $clog2(MAX_STREAK + 1);

    arb_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic grant_i;
    logic grant_d;
    logic streak_inc;
    logic streak_clr;
    logic streak_at_max;
    logic in_busy_i;
    logic in_busy_d;

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        addr_d   = addr_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        grant_i  = 1'b0;
        grant_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dreq_valid && (!bus.ireq_valid || !streak_at_max)) begin
                    grant_d  = 1'b1;
                    state_d  = BUSY_D;
                    write_d  = bus.dreq_write;
                    addr_d   = bus.dreq_addr;
                    strobe_d = bus.dreq_strobe;
                    wdata_d  = bus.dreq_wdata;
                end else if (bus.ireq_valid) begin
                    grant_i  = 1'b1;
                    state_d  = BUSY_I;
                    write_d  = 1'b0;
                    addr_d   = bus.ireq_addr;
                    strobe_d = '0;
                    wdata_d  = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mresp_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            write_q  <= 1'b0;
            addr_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
        end
    end

    // Only a data grant that actually overtakes a waiting fetch lengthens the streak.
    assign streak_inc = grant_d & bus.ireq_valid;
    assign streak_clr = grant_i | (grant_d & ~bus.ireq_valid);

    arb_streak_ctr #(
        .MAX_STREAK (MAX_STREAK),
        .CNT_W      (CNT_W)
    ) u_streak (
        .clk      (clk),
        .rst_n    (resetn),
        .inc_i    (streak_inc),
        .clr_i    (streak_clr),
        .count_o  (dbg_streak),
        .at_max_o (streak_at_max)
    );

    assign in_busy_i = (state_q == BUSY_I);
    assign in_busy_d = (state_q == BUSY_D);
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

    // Downstream port is quiet in IDLE, so the bubble between transactions is all zeros.
    assign bus.mreq_valid  = busy;
    assign bus.mreq_write  = busy ? write_q  : 1'b0;
    assign bus.mreq_addr   = busy ? addr_q   : '0;
    assign bus.mreq_strobe = busy ? strobe_q : '0;
    assign bus.mreq_wdata  = busy ? wdata_q  : '0;

    assign bus.iresp_ok   = in_busy_i & bus.mresp_ok;
    assign bus.dresp_ok   = in_busy_d & bus.mresp_ok;
    assign bus.iresp_data = bus.iresp_ok ? bus.mresp_data : '0;
    assign bus.dresp_data = bus.dresp_ok ? bus.mresp_data : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, data, fairness cap, store latching, spurious ok, reset.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned ADDR_W     = 64;
  localparam int unsigned DATA_W     = 64;
  localparam int unsigned MAX_STREAK = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       busy;
  arb_state_t dbg_state;
  logic [2:0] dbg_streak;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_bus_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .MAX_STREAK (MAX_STREAK)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .bus        (bus),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_streak (dbg_streak)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1);
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.ireq_valid  = 1'b0;
    bus.ireq_addr   = '0;
    bus.dreq_valid  = 1'b0;
    bus.dreq_write  = 1'b0;
    bus.dreq_addr   = '0;
    bus.dreq_strobe = '0;
    bus.dreq_wdata  = '0;
    bus.mresp_ok    = 1'b0;
    bus.mresp_data  = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    repeat (2) sample();
    if (dbg_state !== IDLE) begin $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); tests_failed++; end tests_run++;
    if (busy !== 1'b0) begin $display("FAIL reset_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
    if (bus.mreq_valid !== 1'b0) begin $display("FAIL reset_mreq_valid got=%0b exp=0", bus.mreq_valid); tests_failed++; end tests_run++;
    if (bus.mreq_addr !== 64'h0) begin $display("FAIL reset_mreq_addr got=%h exp=0", bus.mreq_addr); tests_failed++; end tests_run++;
    if (dbg_streak !== 3'd0) begin $display("FAIL reset_streak got=%0d exp=0", dbg_streak); tests_failed++; end tests_run++;
    tick();
    resetn = 1'b1;
  endtask

  task automatic test_single_fetch();
    tick();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h0000_0000_8000_0000;
    sample();
    if (bus.mreq_valid !== 1'b0) begin $display("FAIL fetch_n_mreq_valid got=%0b exp=0", bus.mreq_valid); tests_failed++; end tests_run++;
    tick();
    sample();
    if (bus.mreq_valid !== 1'b1) begin $display("FAIL fetch_n1_mreq_valid got=%0b exp=1", bus.mreq_valid); tests_failed++; end tests_run++;
    if (bus.mreq_addr !== 64'h0000_0000_8000_0000) begin $display("FAIL fetch_n1_addr got=%h exp=80000000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.mreq_write !== 1'b0) begin $display("FAIL fetch_n1_write got=%0b exp=0", bus.mreq_write); tests_failed++; end tests_run++;
    if (dbg_state !== BUSY_I) begin $display("FAIL fetch_n1_state got=%0d exp=%0d", dbg_state, BUSY_I); tests_failed++; end tests_run++;
    tick();
    sample();
    if (bus.iresp_ok !== 1'b0) begin $display("FAIL fetch_n2_iresp_ok got=%0b exp=0", bus.iresp_ok); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'h0000_0013_0000_0093;
    sample();
    if (bus.iresp_ok !== 1'b1) begin $display("FAIL fetch_n3_iresp_ok got=%0b exp=1", bus.iresp_ok); tests_failed++; end tests_run++;
    if (bus.iresp_data !== 64'h0000_0013_0000_0093) begin $display("FAIL fetch_n3_iresp_data got=%h exp=0000001300000093", bus.iresp_data); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b0) begin $display("FAIL fetch_n3_dresp_ok got=%0b exp=0", bus.dresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_data !== 64'h0) begin $display("FAIL fetch_n3_dresp_data got=%h exp=0", bus.dresp_data); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b0;
    bus.ireq_valid = 1'b0;
    sample();
    if (bus.iresp_ok !== 1'b0) begin $display("FAIL fetch_n4_iresp_ok got=%0b exp=0", bus.iresp_ok); tests_failed++; end tests_run++;
    if (busy !== 1'b0) begin $display("FAIL fetch_n4_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
  endtask

  task automatic test_simultaneous();
    tick();
    bus.ireq_valid = 1'b1;
    bus.ireq_addr  = 64'h1000;
    bus.dreq_valid = 1'b1;
    bus.dreq_write = 1'b0;
    bus.dreq_addr  = 64'h2000;
    sample();
    if (dbg_state !== IDLE) begin $display("FAIL simul_arb_state got=%0d exp=%0d", dbg_state, IDLE); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'h55;
    sample();
    if (bus.mreq_addr !== 64'h2000) begin $display("FAIL simul_first_addr got=%h exp=2000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.mreq_write !== 1'b0) begin $display("FAIL simul_first_write got=%0b exp=0", bus.mreq_write); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b1) begin $display("FAIL simul_dresp_ok got=%0b exp=1", bus.dresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_data !== 64'h55) begin $display("FAIL simul_dresp_data got=%h exp=55", bus.dresp_data); tests_failed++; end tests_run++;
    if (bus.iresp_ok !== 1'b0) begin $display("FAIL simul_iresp_quiet got=%0b exp=0", bus.iresp_ok); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b0;
    bus.dreq_valid = 1'b0;
    sample();
    if (bus.mreq_valid !== 1'b0) begin $display("FAIL simul_bubble got=%0b exp=0", bus.mreq_valid); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'h66;
    sample();
    if (bus.mreq_addr !== 64'h1000) begin $display("FAIL simul_second_addr got=%h exp=1000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.iresp_ok !== 1'b1) begin $display("FAIL simul_iresp_ok got=%0b exp=1", bus.iresp_ok); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b0;
    bus.ireq_valid = 1'b0;
    sample();
    if (busy !== 1'b0) begin $display("FAIL simul_end_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
  endtask

  task automatic test_starvation();
    arb_state_t exp_state [10];
    logic [2:0] exp_streak [10];
    exp_state  = '{BUSY_D, BUSY_D, BUSY_D, BUSY_D, BUSY_I, BUSY_D, BUSY_D, BUSY_D, BUSY_D, BUSY_I};
    exp_streak = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.mresp_ok = 1'b0;
      if (k == 0) begin
        bus.ireq_valid = 1'b1;
        bus.ireq_addr  = 64'h3000;
        bus.dreq_valid = 1'b1;
        bus.dreq_write = 1'b0;
        bus.dreq_addr  = 64'h4000;
      end
      sample();
      if (dbg_streak !== exp_streak[k]) begin $display("FAIL starve_streak[%0d] got=%0d exp=%0d", k, dbg_streak, exp_streak[k]); tests_failed++; end tests_run++;
      tick();
      bus.mresp_ok   = 1'b1;
      bus.mresp_data = 64'(k);
      sample();
      if (dbg_state !== exp_state[k]) begin $display("FAIL starve_grant[%0d] got=%0d exp=%0d", k, dbg_state, exp_state[k]); tests_failed++; end tests_run++;
      if (bus.mreq_addr !== ((exp_state[k] == BUSY_I) ? 64'h3000 : 64'h4000)) begin
        $display("FAIL starve_addr[%0d] got=%h exp=%h", k, bus.mreq_addr, (exp_state[k] == BUSY_I) ? 64'h3000 : 64'h4000); tests_failed++;
      end tests_run++;
    end
    tick();
    bus.mresp_ok   = 1'b0;
    bus.ireq_valid = 1'b0;
    bus.dreq_valid = 1'b0;
    sample();
    if (dbg_streak !== 3'd0) begin $display("FAIL starve_final_streak got=%0d exp=0", dbg_streak); tests_failed++; end tests_run++;
  endtask

  task automatic test_store();
    tick();
    bus.dreq_valid  = 1'b1;
    bus.dreq_write  = 1'b1;
    bus.dreq_addr   = 64'h5000;
    bus.dreq_strobe = 8'h0F;
    bus.dreq_wdata  = 64'hDEAD_BEEF;
    sample();
    tick();
    bus.dreq_addr  = 64'h6000;
    bus.dreq_wdata = 64'h1234;
    sample();
    if (bus.mreq_addr !== 64'h5000) begin $display("FAIL store_addr got=%h exp=5000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.mreq_wdata !== 64'hDEAD_BEEF) begin $display("FAIL store_wdata got=%h exp=deadbeef", bus.mreq_wdata); tests_failed++; end tests_run++;
    if (bus.mreq_strobe !== 8'h0F) begin $display("FAIL store_strobe got=%h exp=0f", bus.mreq_strobe); tests_failed++; end tests_run++;
    if (bus.mreq_write !== 1'b1) begin $display("FAIL store_write got=%0b exp=1", bus.mreq_write); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b0) begin $display("FAIL store_early_ok got=%0b exp=0", bus.dresp_ok); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok = 1'b1;
    sample();
    if (bus.mreq_addr !== 64'h5000) begin $display("FAIL store_addr_hold got=%h exp=5000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b1) begin $display("FAIL store_dresp_ok got=%0b exp=1", bus.dresp_ok); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b0;
    bus.dreq_valid = 1'b0;
    bus.dreq_write = 1'b0;
    sample();
    if (bus.dresp_ok !== 1'b0) begin $display("FAIL store_single_pulse got=%0b exp=0", bus.dresp_ok); tests_failed++; end tests_run++;
    if (busy !== 1'b0) begin $display("FAIL store_end_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
  endtask

  task automatic test_spurious_ok();
    tick();
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'hAA;
    sample();
    if (bus.iresp_ok !== 1'b0) begin $display("FAIL spur_iresp_ok got=%0b exp=0", bus.iresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b0) begin $display("FAIL spur_dresp_ok got=%0b exp=0", bus.dresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_data !== 64'h0) begin $display("FAIL spur_dresp_data got=%h exp=0", bus.dresp_data); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok = 1'b0;
    sample();
    if (dbg_state !== IDLE) begin $display("FAIL spur_state got=%0d exp=%0d", dbg_state, IDLE); tests_failed++; end tests_run++;
    if (busy !== 1'b0) begin $display("FAIL spur_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
  endtask

  task automatic test_reset_mid();
    tick();
    bus.dreq_valid = 1'b1;
    bus.dreq_write = 1'b0;
    bus.dreq_addr  = 64'h7000;
    sample();
    tick();
    sample();
    if (dbg_state !== BUSY_D) begin $display("FAIL rmid_pre_state got=%0d exp=%0d", dbg_state, BUSY_D); tests_failed++; end tests_run++;
    #2;
    resetn         = 1'b0;
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'h99;
    #1;
    if (busy !== 1'b0) begin $display("FAIL rmid_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
    if (bus.mreq_valid !== 1'b0) begin $display("FAIL rmid_mreq_valid got=%0b exp=0", bus.mreq_valid); tests_failed++; end tests_run++;
    if (bus.mreq_addr !== 64'h0) begin $display("FAIL rmid_mreq_addr got=%h exp=0", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b0) begin $display("FAIL rmid_dresp_ok got=%0b exp=0", bus.dresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_data !== 64'h0) begin $display("FAIL rmid_dresp_data got=%h exp=0", bus.dresp_data); tests_failed++; end tests_run++;
    bus.mresp_ok = 1'b0;
    tick();
    resetn = 1'b1;
    sample();
    if (dbg_state !== IDLE) begin $display("FAIL rmid_release_state got=%0d exp=%0d", dbg_state, IDLE); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b1;
    bus.mresp_data = 64'h77;
    sample();
    if (bus.mreq_addr !== 64'h7000) begin $display("FAIL rmid_rearb_addr got=%h exp=7000", bus.mreq_addr); tests_failed++; end tests_run++;
    if (bus.dresp_ok !== 1'b1) begin $display("FAIL rmid_rearb_ok got=%0b exp=1", bus.dresp_ok); tests_failed++; end tests_run++;
    if (bus.dresp_data !== 64'h77) begin $display("FAIL rmid_rearb_data got=%h exp=77", bus.dresp_data); tests_failed++; end tests_run++;
    tick();
    bus.mresp_ok   = 1'b0;
    bus.dreq_valid = 1'b0;
    sample();
    if (busy !== 1'b0) begin $display("FAIL rmid_end_busy got=%0b exp=0", busy); tests_failed++; end tests_run++;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_store();
    test_spurious_ok();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
